// File: rtl/cmd_fifo_fwft.sv
// Synchronous command FIFO with selectable registered or first-word-fall-through read port,
// almost-full/empty flags, flush, sticky overflow/underflow flags and traffic counters.
module cmd_fifo_fwft #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 64,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = 48,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_flush,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_full,
  output logic                    o_afull,
  input  logic                    i_rd_en,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic                    o_aempty,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow,
  output logic                    o_underflow,
  input  logic                    i_err_clr,
  output logic [15:0]             o_total_writes,
  output logic [15:0]             o_total_reads
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         ram_cnt_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic [15:0]           total_wr_r;
  logic [15:0]           total_rd_r;

  logic                  wr_go_s;
  logic                  rd_go_s;
  logic                  pop_go_s;
  logic                  ovf_set_s;
  logic                  unf_set_s;
  logic [CW-1:0]         count_nxt_s;
  logic [CW-1:0]         ram_cnt_nxt_s;
  logic                  empty_nxt_s;

  // Accept/pop decisions and next-state occupancy; in FWFT mode the RAM refills the head register
  always_comb begin
    wr_go_s       = 1'b0;
    rd_go_s       = 1'b0;
    pop_go_s      = 1'b0;
    ovf_set_s     = 1'b0;
    unf_set_s     = 1'b0;
    count_nxt_s   = count_r;
    ram_cnt_nxt_s = ram_cnt_r;
    empty_nxt_s   = empty_r;
    if (i_flush) begin
      count_nxt_s   = CNT_ZERO;
      ram_cnt_nxt_s = CNT_ZERO;
      empty_nxt_s   = 1'b1;
    end else begin
      wr_go_s   = i_wr_en && !full_r;
      rd_go_s   = i_rd_en && !empty_r;
      ovf_set_s = i_wr_en && full_r;
      unf_set_s = i_rd_en && empty_r;
      if (FWFT) begin
        pop_go_s = (ram_cnt_r != CNT_ZERO) && (empty_r || rd_go_s);
      end else begin
        pop_go_s = rd_go_s;
      end
      count_nxt_s   = count_r + CW'(wr_go_s) - CW'(rd_go_s);
      ram_cnt_nxt_s = ram_cnt_r + CW'(wr_go_s) - CW'(pop_go_s);
      if (FWFT) begin
        empty_nxt_s = !(pop_go_s || (!empty_r && !rd_go_s));
      end else begin
        empty_nxt_s = (count_nxt_s == CNT_ZERO);
      end
    end
  end

  // Storage array: single write port, no reset so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (wr_go_s) begin
      mem_r[wr_ptr_r] <= i_wr_data;
    end
  end

  // Pointers, occupancy, flags, read/head register, sticky errors and totals
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      ram_cnt_r   <= CNT_ZERO;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      total_wr_r  <= 16'd0;
      total_rd_r  <= 16'd0;
    end else begin
      count_r   <= count_nxt_s;
      ram_cnt_r <= ram_cnt_nxt_s;
      empty_r   <= empty_nxt_s;
      full_r    <= (count_nxt_s == DEPTH_C);
      afull_r   <= (count_nxt_s >= AFULL_C);
      aempty_r  <= (count_nxt_s <= AEMPTY_C);
      if (FWFT) begin
        rd_valid_r <= !empty_nxt_s;
      end else begin
        rd_valid_r <= rd_go_s;
      end
      if (i_flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (wr_go_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_go_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      if (pop_go_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
      // A new error event in the clear cycle keeps the flag set
      overflow_r  <= ovf_set_s || (overflow_r && !i_err_clr);
      underflow_r <= unf_set_s || (underflow_r && !i_err_clr);
      if (wr_go_s) begin
        total_wr_r <= total_wr_r + 16'd1;
      end
      if (rd_go_s) begin
        total_rd_r <= total_rd_r + 16'd1;
      end
    end
  end

  assign o_full         = full_r;
  assign o_afull        = afull_r;
  assign o_empty        = empty_r;
  assign o_aempty       = aempty_r;
  assign o_count        = count_r;
  assign o_rd_data      = rd_data_r;
  assign o_rd_valid     = rd_valid_r;
  assign o_overflow     = overflow_r;
  assign o_underflow    = underflow_r;
  assign o_total_writes = total_wr_r;
  assign o_total_reads  = total_rd_r;

`ifdef SIM
  cmd_fifo_fwft_chk u_chk (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (i_flush),
    .i_wr_en     (i_wr_en),
    .i_rd_en     (i_rd_en),
    .i_full      (full_r),
    .i_empty     (empty_r),
    .i_overflow  (overflow_r),
    .i_underflow (underflow_r)
  );
`endif

endmodule

`ifdef SIM
// Simulation-only checker for the sticky error flags.
module cmd_fifo_fwft_chk (
  input logic i_clk,
  input logic i_reset_n,
  input logic i_flush,
  input logic i_wr_en,
  input logic i_rd_en,
  input logic i_full,
  input logic i_empty,
  input logic i_overflow,
  input logic i_underflow
);
  ovf_a: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                          (i_wr_en && i_full && !i_flush) |=> i_overflow);
  unf_a: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                          (i_rd_en && i_empty && !i_flush) |=> i_underflow);
endmodule
`endif

// File: tb/tb_cmd_fifo_fwft.sv
// Directed bench running a registered-read and an FWFT instance side by side on shared stimulus.
module tb_cmd_fifo_fwft;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wr_en;
  logic        r_rd_en;
  logic        f_rd_en;
  logic        err_clr;
  logic [31:0] wr_data;

  logic        r_full, r_afull, r_rd_valid, r_empty, r_aempty, r_overflow, r_underflow;
  logic [31:0] r_rd_data;
  logic [6:0]  r_count;
  logic [15:0] r_total_writes, r_total_reads;
  logic        f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_overflow, f_underflow;
  logic [31:0] f_rd_data;
  logic [6:0]  f_count;
  logic [15:0] f_total_writes, f_total_reads;

  int errors = 0;
  int checks = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  always #5 clk = ~clk;

  cmd_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(64), .FWFT(1'b0), .AFULL_THRESH(48), .AEMPTY_THRESH(2)) dut_reg (
    .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .o_full(r_full), .o_afull(r_afull), .i_rd_en(r_rd_en), .o_rd_data(r_rd_data),
    .o_rd_valid(r_rd_valid), .o_empty(r_empty), .o_aempty(r_aempty), .o_count(r_count),
    .o_overflow(r_overflow), .o_underflow(r_underflow), .i_err_clr(err_clr),
    .o_total_writes(r_total_writes), .o_total_reads(r_total_reads)
  );

  cmd_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(64), .FWFT(1'b1), .AFULL_THRESH(48), .AEMPTY_THRESH(2)) dut_fwft (
    .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .o_full(f_full), .o_afull(f_afull), .i_rd_en(f_rd_en), .o_rd_data(f_rd_data),
    .o_rd_valid(f_rd_valid), .o_empty(f_empty), .o_aempty(f_aempty), .o_count(f_count),
    .o_overflow(f_overflow), .o_underflow(f_underflow), .i_err_clr(err_clr),
    .o_total_writes(f_total_writes), .o_total_reads(f_total_reads)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    wr_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + 32'(i);
      tick();
      exp_wr++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; r_rd_en = 1'b0; f_rd_en = 1'b0;
    err_clr = 1'b0; wr_data = 32'd0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_wr = 0;
    exp_rd = 0;
    if ({r_full, r_afull, r_empty, r_aempty, r_rd_valid, r_overflow, r_underflow} !== 7'b0011000) begin
      errors++; $display("FAIL reset_flags_r: got %b exp 0011000", {r_full, r_afull, r_empty, r_aempty, r_rd_valid, r_overflow, r_underflow});
    end
    checks++;
    if ({f_full, f_afull, f_empty, f_aempty, f_rd_valid, f_overflow, f_underflow} !== 7'b0011000) begin
      errors++; $display("FAIL reset_flags_f: got %b exp 0011000", {f_full, f_afull, f_empty, f_aempty, f_rd_valid, f_overflow, f_underflow});
    end
    checks++;
    if ({r_count, f_count} !== 14'd0 || r_rd_data !== 32'd0 || f_rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_count_data: got cnt %0d/%0d data %h/%h exp 0", r_count, f_count, r_rd_data, f_rd_data);
    end
    checks++;
    if ({r_total_writes, r_total_reads, f_total_writes, f_total_reads} !== 64'd0) begin
      errors++; $display("FAIL reset_totals: got %0d %0d %0d %0d exp 0", r_total_writes, r_total_reads, f_total_writes, f_total_reads);
    end
    checks++;
  endtask

  task automatic test_fill_drain();
    wr_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_data = 32'h100 + 32'(i);
      tick();
      exp_wr++;
      if (r_count !== 7'(i + 1) || f_count !== 7'(i + 1)) begin
        errors++; $display("FAIL fill_count: got %0d/%0d exp %0d", r_count, f_count, i + 1);
      end
      checks++;
      if ({r_full, r_afull, r_aempty, r_empty} !== {(i == 63), (i >= 47), (i <= 1), 1'b0}) begin
        errors++; $display("FAIL fill_flags_r: got %b at count %0d", {r_full, r_afull, r_aempty, r_empty}, i + 1);
      end
      checks++;
      if ({f_full, f_afull, f_aempty, f_empty} !== {(i == 63), (i >= 47), (i <= 1), (i == 0)}) begin
        errors++; $display("FAIL fill_flags_f: got %b at count %0d", {f_full, f_afull, f_aempty, f_empty}, i + 1);
      end
      checks++;
    end
    wr_en = 1'b0;
    r_rd_en = 1'b1;
    f_rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (f_rd_data !== 32'h100 + 32'(i) || f_rd_valid !== 1'b1) begin
        errors++; $display("FAIL drain_f_data: got %h v%b exp %h v1", f_rd_data, f_rd_valid, 32'h100 + 32'(i));
      end
      checks++;
      tick();
      exp_rd++;
      if (r_rd_data !== 32'h100 + 32'(i) || r_rd_valid !== 1'b1) begin
        errors++; $display("FAIL drain_r_data: got %h v%b exp %h v1", r_rd_data, r_rd_valid, 32'h100 + 32'(i));
      end
      checks++;
      if (r_count !== 7'(63 - i) || f_count !== 7'(63 - i)) begin
        errors++; $display("FAIL drain_count: got %0d/%0d exp %0d", r_count, f_count, 63 - i);
      end
      checks++;
    end
    r_rd_en = 1'b0;
    f_rd_en = 1'b0;
    tick();
    if ({r_rd_valid, r_empty, r_aempty, f_rd_valid, f_empty, f_aempty} !== 6'b011011) begin
      errors++; $display("FAIL drained_flags: got %b exp 011011", {r_rd_valid, r_empty, r_aempty, f_rd_valid, f_empty, f_aempty});
    end
    checks++;
    if (r_rd_data !== 32'h13F || f_rd_data !== 32'h13F) begin
      errors++; $display("FAIL drained_hold: got %h/%h exp 13f", r_rd_data, f_rd_data);
    end
    checks++;
    if (r_total_writes !== 16'(exp_wr) || r_total_reads !== 16'(exp_rd) ||
        f_total_writes !== 16'(exp_wr) || f_total_reads !== 16'(exp_rd)) begin
      errors++; $display("FAIL fill_totals: got %0d/%0d %0d/%0d exp %0d/%0d", r_total_writes, r_total_reads, f_total_writes, f_total_reads, exp_wr, exp_rd);
    end
    checks++;
  endtask

  task automatic test_overflow();
    fill(32'h200, 64);
    wr_en = 1'b1;
    wr_data = 32'hDEAD;
    tick();
    wr_en = 1'b0;
    if ({r_overflow, f_overflow} !== 2'b11 || r_count !== 7'd64 || f_count !== 7'd64) begin
      errors++; $display("FAIL ovf_set: got ovf %b%b cnt %0d/%0d exp 11 64", r_overflow, f_overflow, r_count, f_count);
    end
    checks++;
    if (r_total_writes !== 16'(exp_wr) || f_total_writes !== 16'(exp_wr)) begin
      errors++; $display("FAIL ovf_totals: got %0d/%0d exp %0d", r_total_writes, f_total_writes, exp_wr);
    end
    checks++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    if ({r_overflow, f_overflow} !== 2'b00) begin
      errors++; $display("FAIL ovf_clear: got %b%b exp 00", r_overflow, f_overflow);
    end
    checks++;
    r_rd_en = 1'b1;
    f_rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (f_rd_data !== 32'h200 + 32'(i)) begin
        errors++; $display("FAIL ovf_drain_f: got %h exp %h", f_rd_data, 32'h200 + 32'(i));
      end
      checks++;
      tick();
      exp_rd++;
      if (r_rd_data !== 32'h200 + 32'(i)) begin
        errors++; $display("FAIL ovf_drain_r: got %h exp %h", r_rd_data, 32'h200 + 32'(i));
      end
      checks++;
    end
    r_rd_en = 1'b0;
    f_rd_en = 1'b0;
    tick();
    if ({r_empty, f_empty} !== 2'b11) begin
      errors++; $display("FAIL ovf_drain_empty: got %b%b exp 11", r_empty, f_empty);
    end
    checks++;
  endtask

  task automatic test_underflow();
    r_rd_en = 1'b1;
    f_rd_en = 1'b1;
    tick();
    if ({r_underflow, f_underflow, r_rd_valid, f_rd_valid} !== 4'b1100) begin
      errors++; $display("FAIL unf_set: got %b exp 1100", {r_underflow, f_underflow, r_rd_valid, f_rd_valid});
    end
    checks++;
    if (r_rd_data !== 32'h23F || f_rd_data !== 32'h23F || r_total_reads !== 16'(exp_rd) || f_count !== 7'd0) begin
      errors++; $display("FAIL unf_hold: got %h/%h rd %0d cnt %0d exp 23f %0d 0", r_rd_data, f_rd_data, r_total_reads, exp_rd, f_count);
    end
    checks++;
    err_clr = 1'b1;
    tick();
    if ({r_underflow, f_underflow} !== 2'b11) begin
      errors++; $display("FAIL unf_set_wins: got %b%b exp 11", r_underflow, f_underflow);
    end
    checks++;
    r_rd_en = 1'b0;
    f_rd_en = 1'b0;
    tick();
    err_clr = 1'b0;
    if ({r_underflow, f_underflow} !== 2'b00) begin
      errors++; $display("FAIL unf_clear: got %b%b exp 00", r_underflow, f_underflow);
    end
    checks++;
  endtask

  task automatic test_single_word();
    wr_en = 1'b1;
    wr_data = 32'hA5;
    tick();
    wr_en = 1'b0;
    exp_wr++;
    if ({r_empty, f_empty} !== 2'b01 || f_count !== 7'd1) begin
      errors++; $display("FAIL single_t1: got empty %b%b cnt %0d exp 01 1", r_empty, f_empty, f_count);
    end
    checks++;
    r_rd_en = 1'b1;
    tick();
    r_rd_en = 1'b0;
    if (r_rd_data !== 32'hA5 || r_rd_valid !== 1'b1) begin
      errors++; $display("FAIL single_r_t2: got %h v%b exp a5 v1", r_rd_data, r_rd_valid);
    end
    checks++;
    if (f_rd_data !== 32'hA5 || f_empty !== 1'b0 || f_rd_valid !== 1'b1) begin
      errors++; $display("FAIL single_f_t2: got %h e%b v%b exp a5 e0 v1", f_rd_data, f_empty, f_rd_valid);
    end
    checks++;
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    exp_rd++;
    if ({r_rd_valid, r_empty, f_empty, f_rd_valid} !== 4'b0110 || r_count !== 7'd0 || f_count !== 7'd0) begin
      errors++; $display("FAIL single_t3: got %b cnt %0d/%0d exp 0110 0", {r_rd_valid, r_empty, f_empty, f_rd_valid}, r_count, f_count);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    fill(32'h300, 10);
    wr_en = 1'b1;
    r_rd_en = 1'b1;
    f_rd_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_data = 32'h30A + 32'(k);
      if (f_rd_data !== 32'h300 + 32'(k)) begin
        errors++; $display("FAIL b2b_f_data: got %h exp %h", f_rd_data, 32'h300 + 32'(k));
      end
      checks++;
      tick();
      exp_wr++;
      exp_rd++;
      if (r_rd_data !== 32'h300 + 32'(k) || r_count !== 7'd10 || f_count !== 7'd10) begin
        errors++; $display("FAIL b2b_r_data: got %h cnt %0d/%0d exp %h 10", r_rd_data, r_count, f_count, 32'h300 + 32'(k));
      end
      checks++;
    end
    wr_en = 1'b0;
    r_rd_en = 1'b0;
    f_rd_en = 1'b0;
    if (r_total_writes !== 16'(exp_wr) || f_total_reads !== 16'(exp_rd)) begin
      errors++; $display("FAIL b2b_totals: got %0d/%0d exp %0d/%0d", r_total_writes, f_total_reads, exp_wr, exp_rd);
    end
    checks++;
  endtask

  task automatic test_flush();
    fill(32'h400, 20);
    if (r_count !== 7'd30 || f_count !== 7'd30) begin
      errors++; $display("FAIL flush_pre: got %0d/%0d exp 30", r_count, f_count);
    end
    checks++;
    flush = 1'b1;
    wr_en = 1'b1;
    r_rd_en = 1'b1;
    f_rd_en = 1'b1;
    wr_data = 32'hBAD;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    r_rd_en = 1'b0;
    f_rd_en = 1'b0;
    if (r_count !== 7'd0 || f_count !== 7'd0 ||
        {r_full, r_afull, r_empty, r_aempty, r_rd_valid} !== 5'b00110 ||
        {f_full, f_afull, f_empty, f_aempty, f_rd_valid} !== 5'b00110) begin
      errors++; $display("FAIL flush_state: got cnt %0d/%0d flags %b %b exp 0 00110", r_count, f_count,
                         {r_full, r_afull, r_empty, r_aempty, r_rd_valid}, {f_full, f_afull, f_empty, f_aempty, f_rd_valid});
    end
    checks++;
    if (r_rd_data !== 32'h3C7 || f_rd_data !== 32'h3C8) begin
      errors++; $display("FAIL flush_data_hold: got %h/%h exp 3c7/3c8", r_rd_data, f_rd_data);
    end
    checks++;
    if (r_total_writes !== 16'(exp_wr) || r_total_reads !== 16'(exp_rd) ||
        f_total_writes !== 16'(exp_wr) || f_total_reads !== 16'(exp_rd)) begin
      errors++; $display("FAIL flush_totals: got %0d/%0d %0d/%0d exp %0d/%0d", r_total_writes, r_total_reads, f_total_writes, f_total_reads, exp_wr, exp_rd);
    end
    checks++;
    wr_en = 1'b1;
    wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    r_rd_en = 1'b1;
    tick();
    r_rd_en = 1'b0;
    if (r_rd_data !== 32'h77 || r_rd_valid !== 1'b1 || f_rd_data !== 32'h77 || f_empty !== 1'b0) begin
      errors++; $display("FAIL flush_reuse: got %h v%b / %h e%b exp 77 v1 / 77 e0", r_rd_data, r_rd_valid, f_rd_data, f_empty);
    end
    checks++;
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    exp_wr++;
    exp_rd++;
    if ({r_empty, f_empty} !== 2'b11 || r_total_reads !== 16'(exp_rd) || f_total_writes !== 16'(exp_wr)) begin
      errors++; $display("FAIL flush_reuse_end: got e%b%b rd %0d wr %0d exp e11 %0d %0d", r_empty, f_empty, r_total_reads, f_total_writes, exp_rd, exp_wr);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    fill(32'h500, 3);
    test_reset();
    tick();
    if ({r_empty, f_empty} !== 2'b11 || f_count !== 7'd0) begin
      errors++; $display("FAIL reset_mid_stays_empty: got e%b%b cnt %0d exp e11 0", r_empty, f_empty, f_count);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_single_word();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
